// File: rtl/adder_stim_gen.sv
// Operand-traffic generator for adder energy characterisation: emits packets of
// pattern words separated by idle gaps, feeds a registered adder, counts bus activity.
module adder_stim_gen #(
  parameter int          N    = 16,
  parameter logic [31:0] SEED = 32'hACE10001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [1:0]   mode_i,
  input  logic [7:0]   payload_len_i,
  input  logic [7:0]   gap_len_i,
  input  logic [7:0]   num_pkt_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] op_a_o,
  output logic [N-1:0] op_b_o,
  output logic         op_valid_o,
  output logic [N:0]   sum_o,
  output logic         sum_valid_o,
  output logic [31:0]  toggle_cnt_o,
  output logic [31:0]  cycle_cnt_o
);

  localparam int          W        = 2 * N;
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAPS     = 32'h80200003;
  localparam logic [4:0]  TJ_LAST  = 5'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t       state_q;
  logic [1:0]   mode_q;
  logic [7:0]   plen_q, glen_q, npkt_q;
  logic [7:0]   k_q, pkt_q, gap_q;
  logic [4:0]   tj_q;
  logic [31:0]  lfsr_q;
  logic [W-1:0] word_q;
  logic         op_valid_q, busy_q, done_q, sum_valid_q;
  logic [N:0]   sum_q;
  logic [31:0]  toggle_q, cycle_q;

  logic [1:0]   mode_sel_d;
  logic [31:0]  lfsr_src_d, lfsr_adv_d;
  logic [W-1:0] word_first_d, word_cont_d;
  logic [5:0]   hd_first_d, hd_cont_d;
  logic [4:0]   tj_inc_d;

  function automatic logic [W-1:0] make_word(input logic [1:0] mode, input logic odd,
                                             input logic [4:0] tj, input logic [31:0] lfsr);
    logic [W-1:0] w;
    w = '0;
    case (mode)
      2'd0:    for (int i = 0; i < W; i++) w[i] = (i <= int'(tj));
      2'd1:    w = lfsr[W-1:0];
      2'd2:    w = odd ? '0 : '1;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [5:0] popcount(input logic [W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // In IDLE the word for the start edge comes from the live config and a freshly seeded LFSR.
  always_comb begin
    mode_sel_d   = (state_q == S_IDLE) ? mode_i : mode_q;
    lfsr_src_d   = (state_q == S_IDLE) ? SEED_EFF : lfsr_q;
    lfsr_adv_d   = {1'b0, lfsr_src_d[31:1]} ^ (lfsr_src_d[0] ? TAPS : 32'd0);
    word_first_d = make_word(mode_sel_d, 1'b0, 5'd0, lfsr_adv_d);
    word_cont_d  = make_word(mode_sel_d, k_q[0], tj_q, lfsr_adv_d);
    hd_first_d   = popcount(word_first_d ^ word_q);
    hd_cont_d    = popcount(word_cont_d ^ word_q);
    tj_inc_d     = (tj_q == TJ_LAST) ? 5'd0 : tj_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      plen_q      <= '0;
      glen_q      <= '0;
      npkt_q      <= '0;
      k_q         <= '0;
      pkt_q       <= '0;
      gap_q       <= '0;
      tj_q        <= '0;
      lfsr_q      <= SEED_EFF;
      word_q      <= '0;
      op_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      toggle_q    <= '0;
      cycle_q     <= '0;
    end else begin
      sum_q       <= {1'b0, word_q[N-1:0]} + {1'b0, word_q[W-1:N]};
      sum_valid_q <= op_valid_q;
      if (busy_q) cycle_q <= sat_add(cycle_q, 32'd1);

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q   <= mode_i;
            plen_q   <= payload_len_i;
            glen_q   <= gap_len_i;
            npkt_q   <= num_pkt_i;
            cycle_q  <= '0;
            toggle_q <= '0;
            lfsr_q   <= SEED_EFF;
            if (payload_len_i == 8'd0 || num_pkt_i == 8'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              word_q     <= word_first_d;
              lfsr_q     <= lfsr_adv_d;
              toggle_q   <= 32'(hd_first_d);
              op_valid_q <= 1'b1;
              busy_q     <= 1'b1;
              k_q        <= 8'd1;
              tj_q       <= 5'd1;
              pkt_q      <= 8'd1;
              state_q    <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (k_q != plen_q) begin
            word_q   <= word_cont_d;
            lfsr_q   <= lfsr_adv_d;
            toggle_q <= sat_add(toggle_q, 32'(hd_cont_d));
            k_q      <= k_q + 8'd1;
            tj_q     <= tj_inc_d;
          end else if (glen_q != 8'd0) begin
            op_valid_q <= 1'b0;
            gap_q      <= 8'd1;
            state_q    <= S_GAP;
          end else if (pkt_q == npkt_q) begin
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            // Zero gap: next packet starts straight away with k back at 0.
            word_q   <= word_first_d;
            lfsr_q   <= lfsr_adv_d;
            toggle_q <= sat_add(toggle_q, 32'(hd_first_d));
            k_q      <= 8'd1;
            tj_q     <= 5'd1;
            pkt_q    <= pkt_q + 8'd1;
          end
        end
        S_GAP: begin
          if (gap_q != glen_q) begin
            gap_q <= gap_q + 8'd1;
          end else if (pkt_q == npkt_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            word_q     <= word_first_d;
            lfsr_q     <= lfsr_adv_d;
            toggle_q   <= sat_add(toggle_q, 32'(hd_first_d));
            op_valid_q <= 1'b1;
            k_q        <= 8'd1;
            tj_q       <= 5'd1;
            pkt_q      <= pkt_q + 8'd1;
            state_q    <= S_SEND;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign op_a_o       = word_q[N-1:0];
  assign op_b_o       = word_q[W-1:N];
  assign op_valid_o   = op_valid_q;
  assign sum_o        = sum_q;
  assign sum_valid_o  = sum_valid_q;
  assign toggle_cnt_o = toggle_q;
  assign cycle_cnt_o  = cycle_q;

endmodule

// File: tb/tb_adder_stim_gen.sv
// Randomized bench for adder_stim_gen: a packet-level model builds the expected
// per-cycle output trace of each run, and one compare process checks it every cycle.
module tb_adder_stim_gen;

  localparam logic [31:0] SEED_TB = 32'hACE10001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode  = 2'd0;
  logic [7:0]  plen  = 8'd0, glen = 8'd0, npkt = 8'd0;

  logic        busy, done, op_valid, sum_valid;
  logic [15:0] op_a, op_b;
  logic [16:0] sum;
  logic [31:0] toggle_cnt, cycle_cnt;

  logic        d0_busy, d0_done, d0_op_valid, d0_sum_valid;
  logic [15:0] d0_op_a, d0_op_b;
  logic [16:0] d0_sum;
  logic [31:0] d0_toggle_cnt, d0_cycle_cnt;

  adder_stim_gen #(.N(16), .SEED(SEED_TB)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode),
    .payload_len_i(plen), .gap_len_i(glen), .num_pkt_i(npkt),
    .busy_o(busy), .done_o(done), .op_a_o(op_a), .op_b_o(op_b),
    .op_valid_o(op_valid), .sum_o(sum), .sum_valid_o(sum_valid),
    .toggle_cnt_o(toggle_cnt), .cycle_cnt_o(cycle_cnt)
  );

  adder_stim_gen #(.N(16), .SEED(32'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode),
    .payload_len_i(plen), .gap_len_i(glen), .num_pkt_i(npkt),
    .busy_o(d0_busy), .done_o(d0_done), .op_a_o(d0_op_a), .op_b_o(d0_op_b),
    .op_valid_o(d0_op_valid), .sum_o(d0_sum), .sum_valid_o(d0_sum_valid),
    .toggle_cnt_o(d0_toggle_cnt), .cycle_cnt_o(d0_cycle_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a, b;
    logic        v;
    logic [16:0] s;
    logic        sv, busy, done;
    logic [31:0] tog, cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ce;
  bit          cmp_en = 1'b0;
  logic [31:0] m_ops = '0, m_tog = '0, m_cyc = '0, m_lfsr = '0;
  bit          m_v = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  // One visible cycle of the model: sum/sum_valid look at the previous cycle's bus.
  task automatic push_cycle(input bit v, input logic [31:0] w, input bit bz, input bit dn);
    exp_t e;
    e.s  = {1'b0, m_ops[15:0]} + {1'b0, m_ops[31:16]};
    e.sv = m_v;
    if (v) begin
      m_tog = m_tog + 32'($countones(w ^ m_ops));
      m_ops = w;
    end
    e.a = m_ops[15:0];  e.b = m_ops[31:16];
    e.v = v;  e.busy = bz;  e.done = dn;
    e.tog = m_tog;  e.cyc = m_cyc;
    if (bz) m_cyc = m_cyc + 32'd1;
    m_v = v;
    exp_q.push_back(e);
  endtask

  task automatic build_run(input int md, input int p, input int g, input int n, output int run_len);
    logic [63:0] t;
    logic [31:0] w;
    m_lfsr = SEED_TB;  m_tog = '0;  m_cyc = '0;  run_len = 0;
    if (p != 0 && n != 0) begin
      for (int pk = 0; pk < n; pk++) begin
        for (int k = 0; k < p; k++) begin
          m_lfsr = lfsr_step(m_lfsr);
          t = (64'd1 << ((k % 32) + 1)) - 64'd1;
          case (md)
            0:       w = t[31:0];
            1:       w = m_lfsr;
            2:       w = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
            default: w = 32'h0;
          endcase
          push_cycle(1'b1, w, 1'b1, 1'b0);
          run_len++;
        end
        for (int gg = 0; gg < g; gg++) begin
          push_cycle(1'b0, 32'h0, 1'b1, 1'b0);
          run_len++;
        end
      end
    end
    push_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    run_len++;
    push_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    push_cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Returns at the negedge after the start edge, so index 0 of the run is visible.
  task automatic launch(input int md, input int p, input int g, input int n, output int run_len);
    @(negedge clk);
    mode = 2'(md);  plen = 8'(p);  glen = 8'(g);  npkt = 8'(n);
    start = 1'b1;
    build_run(md, p, g, n, run_len);
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    plen = 8'($urandom_range(0, 255));
    glen = 8'($urandom_range(0, 255));
    npkt = 8'($urandom_range(0, 255));
  endtask

  // Pulse start so that it is sampled at edge j after the run's start edge.
  task automatic extra_start(input int j);
    repeat (j - 1) @(negedge clk);
    mode = 2'($urandom_range(0, 3));
    plen = 8'($urandom_range(1, 9));
    npkt = 8'($urandom_range(1, 3));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
    chk("trace_drained", 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #2;
    if (cmp_en && exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("op_a", 64'(op_a), 64'(ce.a));
      chk("op_b", 64'(op_b), 64'(ce.b));
      chk("op_valid", 64'(op_valid), 64'(ce.v));
      chk("sum", 64'(sum), 64'(ce.s));
      chk("sum_valid", 64'(sum_valid), 64'(ce.sv));
      chk("busy", 64'(busy), 64'(ce.busy));
      chk("done", 64'(done), 64'(ce.done));
      chk("toggle_cnt", 64'(toggle_cnt), 64'(ce.tog));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(ce.cyc));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, vcnt;
    int md, p, g, n;
    logic [31:0] t1w[4];
    logic [16:0] t1s[4];
    logic [15:0] t2a[3];
    t1w = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
    t1s = '{17'h1FFFE, 17'h0, 17'h1FFFE, 17'h0};
    t2a = '{16'h0001, 16'h0003, 16'h0007};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ops", 64'({op_b, op_a}), 64'd0);
    chk("rst_valid", 64'(op_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_tog", 64'(toggle_cnt), 64'd0);
    chk("rst_cyc", 64'(cycle_cnt), 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Alternating pattern, one packet of 4 with a 2-cycle gap.
    launch(2, 4, 2, 1, len);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) chk("t1_word", 64'({op_b, op_a}), 64'(t1w[i]));
      if (i >= 1 && i <= 4) chk("t1_sum", 64'(sum), 64'(t1s[i-1]));
      if (i == 6) begin
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_tog", 64'(toggle_cnt), 64'd128);
        chk("t1_cyc", 64'(cycle_cnt), 64'd6);
      end
      @(negedge clk);
    end
    drain();

    // Thermometer, back-to-back packets.
    launch(0, 3, 0, 2, len);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        chk("t2_op_a", 64'(op_a), 64'(t2a[i % 3]));
        chk("t2_op_b", 64'(op_b), 64'd0);
        chk("t2_valid", 64'(op_valid), 64'd1);
      end else begin
        chk("t2_done", 64'(done), 64'd1);
      end
      @(negedge clk);
    end
    drain();

    // Thermometer wrap at 2N ones.
    launch(0, 34, 1, 1, len);
    repeat (31) @(negedge clk);
    chk("t3_w31", 64'({op_b, op_a}), 64'hFFFF_FFFF);
    @(negedge clk);
    chk("t3_w32", 64'({op_b, op_a}), 64'h1);
    @(negedge clk);
    chk("t3_w33", 64'({op_b, op_a}), 64'h3);
    drain();

    // Empty runs.
    launch(2, 0, 3, 2, len);
    chk("t4p_done", 64'(done), 64'd1);
    chk("t4p_busy", 64'(busy), 64'd0);
    chk("t4p_cyc", 64'(cycle_cnt), 64'd0);
    chk("t4p_tog", 64'(toggle_cnt), 64'd0);
    drain();
    launch(1, 5, 1, 0, len);
    chk("t4n_done", 64'(done), 64'd1);
    chk("t4n_valid", 64'(op_valid), 64'd0);
    drain();

    // LFSR first words for default seed and for a zero seed; start while busy ignored.
    launch(1, 6, 3, 2, len);
    chk("t5_first_word", 64'({op_b, op_a}), 64'hD650_8003);
    chk("t5_seed0_word", 64'({d0_op_b, d0_op_a}), 64'h8020_0003);
    chk("t5_seed0_busy", 64'(d0_busy), 64'd1);
    extra_start(2);
    drain();
    launch(1, 3, 1, 1, len);
    extra_start(len);
    drain();

    // Reset in the middle of SEND.
    launch(1, 10, 2, 2, len);
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_ops", 64'({op_b, op_a}), 64'd0);
    chk("ar_valid", 64'(op_valid), 64'd0);
    chk("ar_sum", 64'({sum_valid, sum}), 64'd0);
    chk("ar_tog", 64'(toggle_cnt), 64'd0);
    chk("ar_cyc", 64'(cycle_cnt), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("ar_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    m_ops = '0;  m_v = 1'b0;  m_tog = '0;  m_cyc = '0;
    cmp_en = 1'b1;

    // Repeated LFSR runs: utilisation visible as valid vs busy cycles.
    for (int r = 0; r < 2; r++) begin
      vcnt = 0;
      launch(1, 7, 3, 3, len);
      for (int i = 0; i < len; i++) begin
        if (op_valid) vcnt++;
        if (i == len - 1) chk("t6_busy_cycles", 64'(cycle_cnt), 64'd30);
        @(negedge clk);
      end
      chk("t6_valid_cycles", 64'(vcnt), 64'd21);
      drain();
    end

    // Random runs, some with an ignored start pulse.
    for (int r = 0; r < 30; r++) begin
      md = $urandom_range(0, 3);
      p  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      g  = $urandom_range(0, 5);
      n  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
      launch(md, p, g, n, len);
      if ($urandom_range(0, 1) == 1) extra_start($urandom_range(1, len));
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
